jtag_cfg_tap: RTL and testbench



---
 rtl/jtag_cfg_tap_if.sv | 50 +++++
 rtl/jtag_cfg_tap.sv | 225 ++++++++++++++++++++++
 tb/tb_jtag_cfg_tap.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_cfg_tap_if.sv
// jtag_cfg_tap_if -- SoC-side bundle of the configuration TAP.
//
// Carries everything the TAP exchanges with the SoC:
//   soc_reg_i          SoC status words, asynchronous to TCK
//   soc_reg_o          configuration register contents
//   reg_upd_o          one-TCK update pulse per register
//   jtag_*_dr_o        Shift/Update/Capture-DR state decodes
//   axireg_sel_o       AXI debug chain selected by the IR
//   dbg_axi_scan_in_o  serial data towards the AXI debug chain
//   dbg_axi_scan_out_i serial return from the AXI debug chain
//
// master: the TAP.  slave: the SoC / debug logic.
interface jtag_cfg_tap_if #(
   parameter int unsigned NUM_REGS  = 2,
   parameter int unsigned REG_WIDTH = 9
);
   logic [NUM_REGS*REG_WIDTH-1:0] soc_reg_i;
   logic [NUM_REGS*REG_WIDTH-1:0] soc_reg_o;
   logic [NUM_REGS-1:0]           reg_upd_o;
   logic                          jtag_shift_dr_o;
   logic                          jtag_update_dr_o;
   logic                          jtag_capture_dr_o;
   logic                          axireg_sel_o;
   logic                          dbg_axi_scan_in_o;
   logic                          dbg_axi_scan_out_i;

   modport master (
      input  soc_reg_i,
      input  dbg_axi_scan_out_i,
      output soc_reg_o,
      output reg_upd_o,
      output jtag_shift_dr_o,
      output jtag_update_dr_o,
      output jtag_capture_dr_o,
      output axireg_sel_o,
      output dbg_axi_scan_in_o
   );

   modport slave (
      output soc_reg_i,
      output dbg_axi_scan_out_i,
      input  soc_reg_o,
      input  reg_upd_o,
      input  jtag_shift_dr_o,
      input  jtag_update_dr_o,
      input  jtag_capture_dr_o,
      input  axireg_sel_o,
      input  dbg_axi_scan_in_o
   );
endinterface

// File: rtl/jtag_cfg_tap.sv
// jtag_cfg_tap -- IEEE 1149.1 TAP with a bank of configuration registers,
// IDCODE, BYPASS and a pass-through AXI debug scan chain.
//
// Ports:
//   tck_i     JTAG clock
//   trst_ni   asynchronous active-low TAP reset
//   tms_i     test mode select (sampled on posedge tck_i)
//   td_i      test data in (sampled on posedge tck_i)
//   td_o      test data out (updated on negedge tck_i)
//   tdo_oe_o  high while shifting IR or DR (registered on negedge)
//   soc       SoC-side bundle (jtag_cfg_tap_if.master)
//
// Config register k lives in bits [k*REG_WIDTH +: REG_WIDTH] of soc_reg_o and
// is selected by opcode CFG_BASE_INSN+k. A TMS-driven Test-Logic-Reset only
// reloads the IR; the config registers are cleared by trst_ni alone so that
// clock-select settings survive TMS resets.
module jtag_cfg_tap #(
   parameter int unsigned                   IR_WIDTH      = 5,
   parameter int unsigned                   NUM_REGS      = 2,
   parameter int unsigned                   REG_WIDTH     = 9,
   parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VAL     = '0,
   parameter logic [31:0]                   IDCODE_VAL    = 32'h1000_0DB3,
   parameter int unsigned                   IDCODE_INSN   = 1,
   parameter int unsigned                   AXIREG_INSN   = 4,
   parameter int unsigned                   CFG_BASE_INSN = 6,
   parameter int unsigned                   SYNC_STAGES   = 2
) (
   input  logic           tck_i,
   input  logic           trst_ni,
   input  logic           tms_i,
   input  logic           td_i,
   output logic           td_o,
   output logic           tdo_oe_o,
   jtag_cfg_tap_if.master soc
);

   localparam int unsigned          TOT_WIDTH  = NUM_REGS * REG_WIDTH;
   localparam logic [IR_WIDTH-1:0]  IR_IDCODE  = IR_WIDTH'(IDCODE_INSN);
   localparam logic [IR_WIDTH-1:0]  IR_AXIREG  = IR_WIDTH'(AXIREG_INSN);
   localparam logic [IR_WIDTH-1:0]  IR_CAPTURE = IR_WIDTH'(1);
   localparam logic [31:0]          IDCODE_CAP = IDCODE_VAL | 32'd1;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET,
      RUN_TEST_IDLE,
      SELECT_DR,
      CAPTURE_DR,
      SHIFT_DR,
      EXIT1_DR,
      PAUSE_DR,
      EXIT2_DR,
      UPDATE_DR,
      SELECT_IR,
      CAPTURE_IR,
      SHIFT_IR,
      EXIT1_IR,
      PAUSE_IR,
      EXIT2_IR,
      UPDATE_IR
   } tap_state_e;

   tap_state_e state_q, state_d;

   logic [IR_WIDTH-1:0]  ir_q;
   logic [IR_WIDTH-1:0]  ir_sr;
   logic                 bypass_sr;
   logic [31:0]          idcode_sr;
   logic [REG_WIDTH-1:0] cfg_sr;
   logic [TOT_WIDTH-1:0] cfg_q;
   logic [TOT_WIDTH-1:0] sync_q [SYNC_STAGES];

   logic                 sel_idcode;
   logic                 sel_axi;
   logic                 sel_cfg;
   logic [NUM_REGS-1:0]  cfg_hit;
   logic [REG_WIDTH-1:0] cfg_cap;
   logic                 dr_lsb;

   // ------------------------------------------------------------------
   // TAP controller
   // ------------------------------------------------------------------
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) state_q <= TEST_LOGIC_RESET;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_DR:        state_d = tms_i ? SELECT_IR        : CAPTURE_DR;
         CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
         SELECT_IR:        state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        state_d = tms_i ? SELECT_DR        : RUN_TEST_IDLE;
         default:          state_d = TEST_LOGIC_RESET;
      endcase
   end

   // ------------------------------------------------------------------
   // Instruction register
   // ------------------------------------------------------------------
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         ir_q  <= IR_IDCODE;
         ir_sr <= '0;
      end else begin
         unique case (state_q)
            TEST_LOGIC_RESET: ir_q  <= IR_IDCODE;
            CAPTURE_IR:       ir_sr <= IR_CAPTURE;
            SHIFT_IR:         ir_sr <= {td_i, ir_sr[IR_WIDTH-1:1]};
            UPDATE_IR:        ir_q  <= ir_sr;
            default: ;
         endcase
      end
   end

   // Decode priority IDCODE > AXIREG > CFG; the all-ones opcode and
   // anything left over fall through to BYPASS.
   always_comb begin
      sel_idcode = (ir_q == IR_IDCODE);
      sel_axi    = !sel_idcode && (ir_q == IR_AXIREG);
      cfg_hit    = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (!sel_idcode && !sel_axi && (ir_q != '1) &&
             (32'(ir_q) == CFG_BASE_INSN + k))
            cfg_hit[k] = 1'b1;
      end
      sel_cfg = |cfg_hit;
   end

   // ------------------------------------------------------------------
   // soc_reg_i synchroniser into the TCK domain (bitwise, no coherency)
   // ------------------------------------------------------------------
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= soc.soc_reg_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   always_comb begin
      cfg_cap = '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (cfg_hit[k]) cfg_cap = sync_q[SYNC_STAGES-1][k*REG_WIDTH +: REG_WIDTH];
      end
   end

   // ------------------------------------------------------------------
   // Data registers; only the selected one captures and shifts
   // ------------------------------------------------------------------
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         bypass_sr <= 1'b0;
         idcode_sr <= '0;
         cfg_sr    <= '0;
      end else begin
         if (state_q == CAPTURE_DR) begin
            bypass_sr <= 1'b0;
            if (sel_idcode) idcode_sr <= IDCODE_CAP;
            if (sel_cfg)    cfg_sr    <= cfg_cap;
         end else if (state_q == SHIFT_DR) begin
            if (sel_idcode)   idcode_sr <= {td_i, idcode_sr[31:1]};
            else if (sel_cfg) cfg_sr    <= (cfg_sr >> 1) | (REG_WIDTH'(td_i) << (REG_WIDTH-1));
            else if (!sel_axi) bypass_sr <= td_i;
         end
      end
   end

   // Config registers: reset only by trst_ni, written in Update-DR.
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         cfg_q <= RESET_VAL;
      end else if (state_q == UPDATE_DR) begin
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (cfg_hit[k]) cfg_q[k*REG_WIDTH +: REG_WIDTH] <= cfg_sr;
         end
      end
   end

   // ------------------------------------------------------------------
   // TDO path, launched on the falling edge
   // ------------------------------------------------------------------
   always_comb begin
      if (sel_idcode)   dr_lsb = idcode_sr[0];
      else if (sel_axi) dr_lsb = soc.dbg_axi_scan_out_i;
      else if (sel_cfg) dr_lsb = cfg_sr[0];
      else              dr_lsb = bypass_sr;
   end

   always_ff @(negedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         td_o     <= 1'b0;
         tdo_oe_o <= 1'b0;
      end else begin
         tdo_oe_o <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
         if (state_q == SHIFT_IR)      td_o <= ir_sr[0];
         else if (state_q == SHIFT_DR) td_o <= dr_lsb;
      end
   end

   // ------------------------------------------------------------------
   // SoC-side outputs
   // ------------------------------------------------------------------
   assign soc.soc_reg_o         = cfg_q;
   assign soc.reg_upd_o         = (state_q == UPDATE_DR) ? cfg_hit : '0;
   assign soc.jtag_shift_dr_o   = (state_q == SHIFT_DR);
   assign soc.jtag_update_dr_o  = (state_q == UPDATE_DR);
   assign soc.jtag_capture_dr_o = (state_q == CAPTURE_DR);
   assign soc.axireg_sel_o      = sel_axi;
   assign soc.dbg_axi_scan_in_o = td_i;

endmodule

// File: tb/tb_jtag_cfg_tap.sv
// tb_jtag_cfg_tap -- self-checking bench for jtag_cfg_tap (default parameters).
// Directed sequences, an opcode table, then random IR/DR/TMS-reset traffic
// checked against a bit-stream model of the TAP data registers.
module tb_jtag_cfg_tap;
   localparam int unsigned NR  = 2;
   localparam int unsigned RW  = 9;
   localparam int unsigned TOT = NR * RW;
   localparam logic [31:0] IDC = 32'h1000_0DB3;

   logic tck = 1'b0, trst_ni = 1'b1, tms_i = 1'b1, td_i = 1'b0;
   logic td_o, tdo_oe_o;

   jtag_cfg_tap_if #(.NUM_REGS(NR), .REG_WIDTH(RW)) sif ();

   jtag_cfg_tap #(.IR_WIDTH(5), .NUM_REGS(NR), .REG_WIDTH(RW)) dut (
      .tck_i(tck), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i),
      .td_o(td_o), .tdo_oe_o(tdo_oe_o), .soc(sif)
   );

   always #5 tck = ~tck;

   int nvec = 0, nfail = 0;

   typedef struct packed {
      logic          tdo, oe, cap, sh, updr;
      logic [NR-1:0] upd;
   } samp_t;

   typedef struct {
      logic [4:0]     insn;
      logic           axisel;
      logic [31:0]    dout;
      logic [NR-1:0]  upd;
      logic [TOT-1:0] soc;
   } vec_t;

   // reference model state
   logic [4:0]     m_ir;
   logic [TOT-1:0] m_regs;
   logic [TOT-1:0] m_soc_in;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic tms, input logic tdi, output samp_t s);
      tms_i = tms;
      td_i  = tdi;
      @(posedge tck); #2;
      s.cap  = sif.jtag_capture_dr_o;
      s.sh   = sif.jtag_shift_dr_o;
      s.updr = sif.jtag_update_dr_o;
      s.upd  = sif.reg_upd_o;
      @(negedge tck); #2;
      s.tdo = td_o;
      s.oe  = tdo_oe_o;
   endtask

   task automatic idle(input int n);
      samp_t s;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, s);
   endtask

   task automatic tms_reset();
      samp_t s;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
   endtask

   task automatic do_trst();
      trst_ni = 1'b0;
      #2;
      @(negedge tck); #2;
      trst_ni = 1'b1;
   endtask

   // From Run-Test/Idle back to Run-Test/Idle through the IR column.
   task automatic ir_scan(input logic [4:0] insn, output logic [4:0] cap_out);
      samp_t s;
      cap_out = '0;
      step(1'b1, 1'b0, s);
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      step(1'b0, 1'b0, s);
      cap_out[0] = s.tdo;
      for (int i = 0; i < 5; i++) begin
         step(i == 4, insn[i], s);
         if (i < 4) cap_out[i+1] = s.tdo;
      end
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
   endtask

   // From Run-Test/Idle back to Run-Test/Idle through the DR column.
   // bad counts strobe/oe samples that are wrong for the state visited.
   task automatic dr_scan(input int len, input logic [63:0] din, output logic [63:0] dout,
                          output logic [NR-1:0] upd_pulse, output logic [NR-1:0] upd_after,
                          output int bad);
      samp_t s;
      dout = '0;
      bad  = 0;
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      if (!s.cap || s.oe) bad++;
      step(1'b0, 1'b0, s);
      if (!s.sh || !s.oe) bad++;
      dout[0] = s.tdo;
      for (int i = 0; i < len; i++) begin
         step(i == len - 1, din[i], s);
         if (i < len - 1) begin
            dout[i+1] = s.tdo;
            if (!s.sh || !s.oe) bad++;
         end else if (s.sh || s.oe) bad++;
      end
      step(1'b1, 1'b0, s);
      if (!s.updr) bad++;
      upd_pulse = s.upd;
      step(1'b0, 1'b0, s);
      upd_after = s.upd;
   endtask

   // DR behaviour as a bit stream: captured bits followed by the bits shifted
   // in; the first len bits come out, the next W bits are left in the register.
   task automatic model_dr(input int len, input logic [63:0] din,
                           output logic [63:0] exp_out, output logic [NR-1:0] exp_upd);
      logic  q[$];
      int    w, k;
      logic [31:0] cap;
      k = -1;
      if (m_ir == 5'd1) begin
         w = 32; cap = IDC | 32'd1;
      end else if (m_ir != 5'h1F && m_ir >= 6 && m_ir < 6 + NR) begin
         k = int'(m_ir) - 6; w = RW; cap = 32'(m_soc_in[k*RW +: RW]);
      end else begin
         w = 1; cap = '0;
      end
      for (int i = 0; i < w; i++)   q.push_back(cap[i]);
      for (int i = 0; i < len; i++) q.push_back(din[i]);
      exp_out = '0;
      for (int i = 0; i < len; i++) exp_out[i] = q[i];
      exp_upd = '0;
      if (k >= 0) begin
         exp_upd[k] = 1'b1;
         for (int i = 0; i < RW; i++) m_regs[k*RW + i] = q[len + i];
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t           tbl[11];
      samp_t          s;
      logic [4:0]     irc;
      logic [63:0]    dout, eout;
      logic [NR-1:0]  up, ua, eu;
      int             bad, op, len;
      logic [7:0]     pa, pt, got_o, got_i;

      tbl[0]  = '{5'h01, 1'b0, 32'h1000_0DB3, 2'b00, 18'h00000};
      tbl[1]  = '{5'h04, 1'b1, 32'h0000_0000, 2'b00, 18'h00000};
      tbl[2]  = '{5'h06, 1'b0, 32'hFFFF_FF5C, 2'b01, 18'h001FF};
      tbl[3]  = '{5'h07, 1'b0, 32'hFFFF_FF52, 2'b10, 18'h3FFFF};
      tbl[4]  = '{5'h1F, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[5]  = '{5'h00, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[6]  = '{5'h02, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[7]  = '{5'h03, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[8]  = '{5'h05, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[9]  = '{5'h08, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};
      tbl[10] = '{5'h1E, 1'b0, 32'hFFFF_FFFE, 2'b00, 18'h3FFFF};

      sif.soc_reg_i          = '0;
      sif.dbg_axi_scan_out_i = 1'b0;

      // ---- asynchronous reset values
      #1 trst_ni = 1'b0;
      #3;
      check("rst_td_o", td_o, 1'b0);
      check("rst_tdo_oe", tdo_oe_o, 1'b0);
      check("rst_soc_reg_o", sif.soc_reg_o, 18'h0);
      check("rst_reg_upd", sif.reg_upd_o, 2'b00);
      check("rst_dr_strobes", {sif.jtag_shift_dr_o, sif.jtag_update_dr_o, sif.jtag_capture_dr_o}, 3'b000);
      check("rst_axisel", sif.axireg_sel_o, 1'b0);
      @(negedge tck); #2;
      trst_ni = 1'b1;

      // ---- IDCODE straight out of reset, no IR scan
      step(1'b0, 1'b0, s);
      dr_scan(32, 64'h0, dout, up, ua, bad);
      check("idcode_after_trst", dout, 64'h1000_0DB3);
      check("idcode_strobes_oe", bad, 0);

      // ---- BYPASS: one-cycle delay with a leading 0
      ir_scan(5'h1F, irc);
      check("ir_capture_bypass", irc, 5'b00001);
      dr_scan(8, 64'hA5, dout, up, ua, bad);
      check("bypass_a5", dout, 64'h4A);

      // ---- config register 0 capture/update
      sif.soc_reg_i = 18'h0_00AB;
      idle(3);
      ir_scan(5'h06, irc);
      dr_scan(9, 64'h1C3, dout, up, ua, bad);
      check("cfg0_capture", dout, 64'h0AB);
      check("cfg0_upd_pulse", up, 2'b01);
      check("cfg0_upd_after", ua, 2'b00);
      check("cfg0_soc_reg_o", sif.soc_reg_o, 18'h001C3);
      check("cfg0_strobes_oe", bad, 0);

      // ---- TMS reset reloads IDCODE but keeps config
      tms_reset();
      dr_scan(32, 64'h0, dout, up, ua, bad);
      check("tms_reset_idcode", dout, 64'h1000_0DB3);
      check("tms_reset_keeps_cfg", sif.soc_reg_o, 18'h001C3);
      ir_scan(5'h1F, irc);
      check("ir_capture_after_tmsrst", irc, 5'b00001);

      // ---- AXI debug chain pass-through
      ir_scan(5'h04, irc);
      check("axi_sel", sif.axireg_sel_o, 1'b1);
      pa = 8'h3C; pt = 8'h96; got_o = '0; got_i = '0;
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      for (int i = 0; i < 8; i++) begin
         sif.dbg_axi_scan_out_i = pa[i];
         step(1'b0, pt[i], s);
         got_o[i] = s.tdo;
         got_i[i] = sif.dbg_axi_scan_in_o;
      end
      step(1'b1, 1'b0, s);
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      sif.dbg_axi_scan_out_i = 1'b0;
      check("axi_td_o_follows_return", got_o, pa);
      check("axi_scan_in_follows_td_i", got_i, pt);

      // ---- trst in the middle of a Shift-DR on config register 1
      ir_scan(5'h07, irc);
      step(1'b1, 1'b0, s);
      step(1'b0, 1'b0, s);
      step(1'b0, 1'b0, s);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, s);
      #1 trst_ni = 1'b0;
      #1;
      check("trst_mid_soc_reg_o", sif.soc_reg_o, 18'h0);
      check("trst_mid_reg_upd", sif.reg_upd_o, 2'b00);
      check("trst_mid_shift_dr", sif.jtag_shift_dr_o, 1'b0);
      check("trst_mid_tdo_oe", tdo_oe_o, 1'b0);
      @(negedge tck); #2;
      trst_ni = 1'b1;
      step(1'b0, 1'b0, s);
      check("trst_mid_no_upd", s.upd, 2'b00);
      dr_scan(32, 64'h0, dout, up, ua, bad);
      check("trst_mid_idcode", dout, 64'h1000_0DB3);
      check("trst_mid_strobes", bad, 0);

      // ---- opcode table
      sif.soc_reg_i = 18'h2_A55C;
      do_trst();
      step(1'b0, 1'b0, s);
      idle(3);
      for (int r = 0; r < 11; r++) begin
         ir_scan(tbl[r].insn, irc);
         check("tbl_ir_capture", irc, 5'b00001);
         check("tbl_axisel", sif.axireg_sel_o, tbl[r].axisel);
         dr_scan(32, 64'hFFFF_FFFF, dout, up, ua, bad);
         check("tbl_dr_out", dout, 64'(tbl[r].dout));
         check("tbl_reg_upd", up, tbl[r].upd);
         check("tbl_soc_reg_o", sif.soc_reg_o, tbl[r].soc);
      end

      // ---- random traffic against the model
      m_soc_in      = TOT'($urandom);
      sif.soc_reg_i = m_soc_in;
      m_regs        = '0;
      m_ir          = 5'd1;
      do_trst();
      step(1'b0, 1'b0, s);
      idle(3);
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 4))
            0: begin
               m_soc_in      = TOT'($urandom);
               sif.soc_reg_i = m_soc_in;
               idle(3);
            end
            1: begin
               if ($urandom_range(0, 1) == 1) op = 6 + int'($urandom_range(0, NR - 1));
               else begin
                  op = int'($urandom_range(0, 31));
                  if (op == 4) op = 1;
               end
               ir_scan(5'(op), irc);
               check("rand_ir_capture", irc, 5'b00001);
               m_ir = 5'(op);
            end
            2, 3: begin
               len  = int'($urandom_range(1, 40));
               dout = {$urandom, $urandom};
               model_dr(len, dout, eout, eu);
               dr_scan(len, dout, dout, up, ua, bad);
               check("rand_dr_out", dout, eout);
               check("rand_reg_upd", up, eu);
               check("rand_upd_one_cycle", ua, 2'b00);
               check("rand_soc_reg_o", sif.soc_reg_o, m_regs);
            end
            default: begin
               tms_reset();
               m_ir = 5'd1;
               check("rand_tmsrst_soc_reg_o", sif.soc_reg_o, m_regs);
            end
         endcase
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
